// File: rtl/mul_sched.sv
// mul_sched: round-robin scheduler and sequencer that shares one iterative multiplier between two requesters.
// Optional feature macro MUL_FAST_PATH_EN enables the single-cycle MUL path for 16-bit-representable operands.
module mul_sched (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req0_valid_i,
    input  logic        req1_valid_i,
    output logic        req0_ready_o,
    output logic        req1_ready_o,
    input  logic [1:0]  req0_op_i,
    input  logic [1:0]  req1_op_i,
    input  logic [31:0] req0_a_i,
    input  logic [31:0] req0_b_i,
    input  logic [31:0] req1_a_i,
    input  logic [31:0] req1_b_i,
    output logic        rsp0_valid_o,
    output logic        rsp1_valid_o,
    input  logic        rsp0_ready_i,
    input  logic        rsp1_ready_i,
    output logic [31:0] rsp_result_o,
    output logic [31:0] mul_first_operand_o,
    output logic [31:0] mul_second_operand_o,
    output logic [1:0]  mul_signed_mode_o,
    output logic        mul_enable_o,
    output logic        mul_low_o,
    output logic        mul_single_cycle_o,
    output logic        mul_stall_o,
    input  logic        mul_hold_i,
    input  logic [31:0] mul_result_i
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        owner_q, owner_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [1:0]  mode_q, mode_d;
    logic        low_q, low_d;
    logic        single_q, single_d;

    logic        any_valid;
    logic        grant;
    logic [1:0]  sel_op;
    logic [31:0] sel_a;
    logic [31:0] sel_b;
    logic [1:0]  dec_mode;
    logic        dec_low;
    logic        dec_single;
    logic        fast_ok;
    logic [1:0]  fast_mode;
    logic        owner_rsp_ready;

    // A tie goes to whichever requester was not served last.
    always_comb begin
        any_valid = req0_valid_i | req1_valid_i;
        if (req0_valid_i && req1_valid_i) begin
            grant = ~last_grant_q;
        end else begin
            grant = req1_valid_i;
        end
        sel_op = grant ? req1_op_i : req0_op_i;
        sel_a  = grant ? req1_a_i  : req0_a_i;
        sel_b  = grant ? req1_b_i  : req0_b_i;
    end

`ifdef MUL_FAST_PATH_EN
    logic a_pos, a_neg, b_pos, b_neg;
    assign a_pos     = (sel_a[31:16] == 16'h0000);
    assign a_neg     = &sel_a[31:15];
    assign b_pos     = (sel_b[31:16] == 16'h0000);
    assign b_neg     = &sel_b[31:15];
    assign fast_ok   = (sel_op == 2'b00) && (a_pos || a_neg) && (b_pos || b_neg);
    assign fast_mode = {b_neg, a_neg};
`else
    assign fast_ok   = 1'b0;
    assign fast_mode = 2'b00;
`endif

    always_comb begin
        dec_mode   = 2'b00;
        dec_low    = 1'b0;
        dec_single = 1'b0;
        case (sel_op)
            2'b00: begin
                dec_low = 1'b1;
                if (fast_ok) begin
                    dec_single = 1'b1;
                    dec_mode   = fast_mode;
                end
            end
            2'b01:   dec_mode = 2'b11;
            2'b10:   dec_mode = 2'b01;
            default: dec_mode = 2'b00;
        endcase
    end

    // Backpressure freezes the multiplier on its final step instead of buffering the result.
    always_comb begin
        state_d         = state_q;
        last_grant_d    = last_grant_q;
        owner_d         = owner_q;
        a_d             = a_q;
        b_d             = b_q;
        mode_d          = mode_q;
        low_d           = low_q;
        single_d        = single_q;
        req0_ready_o    = 1'b0;
        req1_ready_o    = 1'b0;
        rsp0_valid_o    = 1'b0;
        rsp1_valid_o    = 1'b0;
        mul_enable_o    = 1'b0;
        mul_stall_o     = 1'b0;
        owner_rsp_ready = owner_q ? rsp1_ready_i : rsp0_ready_i;
        case (state_q)
            IDLE: begin
                req0_ready_o = any_valid & ~grant;
                req1_ready_o = any_valid & grant;
                if (any_valid) begin
                    state_d  = BUSY;
                    owner_d  = grant;
                    a_d      = sel_a;
                    b_d      = sel_b;
                    mode_d   = dec_mode;
                    low_d    = dec_low;
                    single_d = dec_single;
                end
            end
            BUSY: begin
                mul_enable_o = 1'b1;
                if (!mul_hold_i) begin
                    rsp0_valid_o = ~owner_q;
                    rsp1_valid_o = owner_q;
                    if (owner_rsp_ready) begin
                        state_d      = IDLE;
                        last_grant_d = owner_q;
                    end else begin
                        mul_stall_o = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            a_q          <= 32'h0;
            b_q          <= 32'h0;
            mode_q       <= 2'b00;
            low_q        <= 1'b0;
            single_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            a_q          <= a_d;
            b_q          <= b_d;
            mode_q       <= mode_d;
            low_q        <= low_d;
            single_q     <= single_d;
        end
    end

    assign mul_first_operand_o  = a_q;
    assign mul_second_operand_o = b_q;
    assign mul_signed_mode_o    = mode_q;
    assign mul_low_o            = low_q;
    assign mul_single_cycle_o   = single_q;
    assign rsp_result_o         = mul_result_i;

endmodule

// File: tb/tb_mul_sched.sv
// tb_mul_sched: randomized self-checking bench for mul_sched with a behavioural multiplier and
// a transaction-level RV32M reference model (latency, decode, result, arbitration order).
module tb_mul_sched;

    logic        clk;
    logic        reset_n;
    logic        req0_valid_i, req1_valid_i;
    logic        req0_ready_o, req1_ready_o;
    logic [1:0]  req0_op_i, req1_op_i;
    logic [31:0] req0_a_i, req0_b_i, req1_a_i, req1_b_i;
    logic        rsp0_valid_o, rsp1_valid_o;
    logic        rsp0_ready_i, rsp1_ready_i;
    logic [31:0] rsp_result_o;
    logic [31:0] mul_first_operand_o, mul_second_operand_o;
    logic [1:0]  mul_signed_mode_o;
    logic        mul_enable_o, mul_low_o, mul_single_cycle_o, mul_stall_o;
    logic        mul_hold_i;
    logic [31:0] mul_result_i;

    int check_count = 0;
    int error_count = 0;

    mul_sched dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .req0_valid_i         (req0_valid_i),
        .req1_valid_i         (req1_valid_i),
        .req0_ready_o         (req0_ready_o),
        .req1_ready_o         (req1_ready_o),
        .req0_op_i            (req0_op_i),
        .req1_op_i            (req1_op_i),
        .req0_a_i             (req0_a_i),
        .req0_b_i             (req0_b_i),
        .req1_a_i             (req1_a_i),
        .req1_b_i             (req1_b_i),
        .rsp0_valid_o         (rsp0_valid_o),
        .rsp1_valid_o         (rsp1_valid_o),
        .rsp0_ready_i         (rsp0_ready_i),
        .rsp1_ready_i         (rsp1_ready_i),
        .rsp_result_o         (rsp_result_o),
        .mul_first_operand_o  (mul_first_operand_o),
        .mul_second_operand_o (mul_second_operand_o),
        .mul_signed_mode_o    (mul_signed_mode_o),
        .mul_enable_o         (mul_enable_o),
        .mul_low_o            (mul_low_o),
        .mul_single_cycle_o   (mul_single_cycle_o),
        .mul_stall_o          (mul_stall_o),
        .mul_hold_i           (mul_hold_i),
        .mul_result_i         (mul_result_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural multiplier: counts enabled, unstalled cycles and releases hold on its last step.
    logic [3:0]  mul_cnt;
    int          mul_lat;
    logic [63:0] mul_pa, mul_pb, mul_prod;

    always_comb mul_lat = mul_single_cycle_o ? 2 : (mul_low_o ? 4 : 5);
    assign mul_hold_i = !(mul_enable_o && (int'(mul_cnt) >= mul_lat - 1));
    assign mul_pa = mul_signed_mode_o[0] ? {{32{mul_first_operand_o[31]}}, mul_first_operand_o}
                                         : {32'h0, mul_first_operand_o};
    assign mul_pb = mul_signed_mode_o[1] ? {{32{mul_second_operand_o[31]}}, mul_second_operand_o}
                                         : {32'h0, mul_second_operand_o};
    assign mul_prod = mul_pa * mul_pb;
    assign mul_result_i = mul_low_o ? mul_prod[31:0] : mul_prod[63:32];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)                          mul_cnt <= 4'd0;
        else if (!mul_enable_o)                mul_cnt <= 4'd0;
        else if (!mul_stall_o && mul_cnt < 15) mul_cnt <= mul_cnt + 4'd1;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference model: RV32M semantics with plain 64-bit arithmetic.
    function automatic logic [31:0] refResult(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        sa = $signed(a);
        sb = $signed(b);
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        case (op)
            2'b00:   p = sa * sb;
            2'b01:   p = sa * sb;
            2'b10:   p = sa * ub;
            default: p = ua * ub;
        endcase
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic bit fits16(input logic [31:0] x);
        longint v;
        v = $signed(x);
        return (v >= -32768) && (v <= 65535);
    endfunction

    function automatic bit refFast(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef MUL_FAST_PATH_EN
        return (op == 2'b00) && fits16(a) && fits16(b);
`else
        return (op == 2'b00) && fits16(a) && fits16(b) && 1'b0;
`endif
    endfunction

    function automatic logic [1:0] refMode(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            2'b01:   return 2'b11;
            2'b10:   return 2'b01;
            2'b11:   return 2'b00;
            default: return refFast(op, a, b) ? {b[31], a[31]} : 2'b00;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic driveReq(input bit req, input bit valid, input logic [1:0] op,
                            input logic [31:0] a, input logic [31:0] b);
        if (req) begin
            req1_valid_i = valid; req1_op_i = op; req1_a_i = a; req1_b_i = b;
        end else begin
            req0_valid_i = valid; req0_op_i = op; req0_a_i = a; req0_b_i = b;
        end
    endtask

    task automatic setRspReady(input bit req, input bit rdy);
        if (req) rsp1_ready_i = rdy;
        else     rsp0_ready_i = rdy;
    endtask

    task automatic checkResetOutputs();
        checkOutput("rst_ctrl", {req0_ready_o, req1_ready_o, rsp0_valid_o, rsp1_valid_o, mul_enable_o,
                                 mul_stall_o, mul_low_o, mul_single_cycle_o, mul_signed_mode_o}, 0);
        checkOutput("rst_opa", mul_first_operand_o, 0);
        checkOutput("rst_opb", mul_second_operand_o, 0);
        checkOutput("rst_result", rsp_result_o, 0);
    endtask

    task automatic doReset();
        @(negedge clk);
        reset_n = 1'b0;
        req0_valid_i = 1'b0; req1_valid_i = 1'b0;
        rsp0_ready_i = 1'b0; rsp1_ready_i = 1'b0;
        #1;
        checkResetOutputs();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // One complete transaction from an idle scheduler, with stall_cycles of response backpressure.
    task automatic applyStimulus(input bit req, input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input int stall_cycles);
        logic [31:0] exp_res;
        bit          fast;
        int          exp_lat;
        int          lat;
        bit          got;
        logic        own_valid;
        exp_res = refResult(op, a, b);
        fast    = refFast(op, a, b);
        exp_lat = fast ? 2 : ((op == 2'b00) ? 4 : 5);

        @(negedge clk);
        driveReq(req, 1'b1, op, a, b);
        setRspReady(req, stall_cycles == 0);
        setRspReady(!req, 1'($urandom));
        #1;
        checkOutput("accept_ready", req ? {req1_ready_o, req0_ready_o} : {req0_ready_o, req1_ready_o}, 2'b10);

        @(negedge clk);
        driveReq(req, 1'b0, 2'($urandom), $urandom, $urandom);
        #1;
        checkOutput("busy_enable", mul_enable_o, 1);
        checkOutput("busy_req_ready", {req0_ready_o, req1_ready_o}, 0);
        checkOutput("busy_operands", {mul_first_operand_o, mul_second_operand_o}, {a, b});
        checkOutput("busy_decode", {mul_low_o, mul_single_cycle_o, mul_signed_mode_o},
                    {op == 2'b00, fast, refMode(op, a, b)});

        lat = 1;
        got = 1'b0;
        while (!got && lat < 12) begin
            if (rsp0_valid_o || rsp1_valid_o) got = 1'b1;
            else begin
                @(negedge clk);
                #1;
                lat++;
            end
        end
        if (!got) begin
            checkOutput("rsp_timeout", 0, 1);
            doReset();
            return;
        end
        checkOutput("rsp_latency", lat, exp_lat);
        checkOutput("rsp_owner", {rsp1_valid_o, rsp0_valid_o}, req ? 2'b10 : 2'b01);
        checkOutput("rsp_result", rsp_result_o, exp_res);

        for (int s = 0; s < stall_cycles; s++) begin
            own_valid = req ? rsp1_valid_o : rsp0_valid_o;
            checkOutput("stall_flag", mul_stall_o, 1);
            checkOutput("stall_valid", own_valid, 1);
            checkOutput("stall_result", rsp_result_o, exp_res);
            @(negedge clk);
            if (s == stall_cycles - 1) setRspReady(req, 1'b1);
            #1;
        end
        own_valid = req ? rsp1_valid_o : rsp0_valid_o;
        checkOutput("complete_stall", mul_stall_o, 0);
        checkOutput("complete_valid", own_valid, 1);
        checkOutput("complete_result", rsp_result_o, exp_res);

        @(negedge clk);
        setRspReady(req, 1'b0);
        #1;
        checkOutput("idle_after", {mul_enable_o, rsp0_valid_o, rsp1_valid_o}, 0);
    endtask

    function automatic logic [31:0] pickOperand();
        logic [31:0] r;
        logic [31:0] edges [7];
        edges = '{32'h0, 32'h0000_8000, 32'hFFFF_8000, 32'h0001_0000,
                  32'hFFFF_7FFF, 32'h7FFF_FFFF, 32'h8000_0000};
        r = $urandom;
        case ($urandom_range(0, 3))
            0:       return {16'h0, r[15:0]};
            1:       return {17'h1FFFF, r[14:0]};
            2:       return r;
            default: return edges[$urandom_range(0, 6)];
        endcase
    endfunction

    initial begin
        int  accepts;
        int  responses;
        bit  exp_grant;
        bit  cur_owner;

        reset_n = 1'b0;
        req0_valid_i = 1'b0; req1_valid_i = 1'b0;
        req0_op_i = 2'b00; req1_op_i = 2'b00;
        req0_a_i = 32'h0; req0_b_i = 32'h0; req1_a_i = 32'h0; req1_b_i = 32'h0;
        rsp0_ready_i = 1'b0; rsp1_ready_i = 1'b0;
        #1;
        checkResetOutputs();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        $display("[TB] directed transactions");
        applyStimulus(1'b0, 2'b00, 32'd7,          32'hFFFF_FFFD, 0);
        applyStimulus(1'b1, 2'b01, 32'h8000_0000,  32'h8000_0000, 0);
        applyStimulus(1'b0, 2'b11, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 2);
        applyStimulus(1'b1, 2'b10, 32'hFFFF_FFFF,  32'd2,         1);
        applyStimulus(1'b0, 2'b00, 32'h0001_8000,  32'd2,         0);
        applyStimulus(1'b0, 2'b01, 32'h1234_5678,  32'h9ABC_DEF0, 6);

        $display("[TB] reset during an operation");
        @(negedge clk);
        driveReq(1'b1, 1'b1, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rsp1_ready_i = 1'b1;
        #1;
        checkOutput("midrst_accept", req1_ready_o, 1);
        @(negedge clk);
        driveReq(1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checkResetOutputs();
        @(negedge clk);
        reset_n = 1'b1;
        rsp1_ready_i = 1'b0;
        #1;
        checkOutput("midrst_idle", {mul_enable_o, rsp0_valid_o, rsp1_valid_o}, 0);
        applyStimulus(1'b1, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);

        $display("[TB] round-robin with both requesters valid");
        doReset();
        @(negedge clk);
        driveReq(1'b0, 1'b1, 2'b00, 32'h0001_0000, 32'd3);
        driveReq(1'b1, 1'b1, 2'b00, 32'h0001_0000, 32'd3);
        rsp0_ready_i = 1'b1;
        rsp1_ready_i = 1'b1;
        accepts   = 0;
        responses = 0;
        exp_grant = 1'b0;
        cur_owner = 1'b0;
        for (int c = 0; c < 200 && responses < 10; c++) begin
            if (c != 0) @(negedge clk);
            #1;
            if (req0_ready_o || req1_ready_o) begin
                checkOutput("arb_grant", {req1_ready_o, req0_ready_o}, exp_grant ? 2'b10 : 2'b01);
                cur_owner = exp_grant;
                exp_grant = ~exp_grant;
                accepts++;
            end
            if (rsp0_valid_o || rsp1_valid_o) begin
                checkOutput("arb_rsp_owner", {rsp1_valid_o, rsp0_valid_o}, cur_owner ? 2'b10 : 2'b01);
                checkOutput("arb_result", rsp_result_o, 32'h0003_0000);
                responses++;
            end
        end
        @(negedge clk);
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
        rsp0_ready_i = 1'b0;
        rsp1_ready_i = 1'b0;
        checkOutput("arb_responses", responses, 10);
        checkOutput("arb_accepts", accepts, 10);
        @(negedge clk);
        @(negedge clk);
        #1;
        checkOutput("arb_drain", {mul_enable_o, rsp0_valid_o, rsp1_valid_o}, 0);

        $display("[TB] randomized transactions");
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'($urandom), 2'($urandom), pickOperand(), pickOperand(), $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
